multiword_add_seq: RTL

- Sequencer that performs wide additions by reusing one 16-bit ripple-carry adder across several cycles, least-significant word first.
- A registered carry links consecutive words.
- Sits between a requester issuing wide operands and the existing 16-bit adder datapath.
- Uses valid/ready handshakes on both input and output sides.

---
 rtl/mwadd_pkg.sv | 23 ++
 rtl/multiword_add_seq_rca16.sv | 22 ++
 rtl/multiword_add_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mwadd_pkg.sv
// Shared definitions for the multi-word add sequencer: word width, FSM encoding
// and the index-width helper.
package mwadd_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to index n words; callers guarantee n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multiword_add_seq_rca16.sv
// Existing 16-bit ripple-carry adder datapath: S = A1 + A2 + in, carry out on C.
module RCA16 (
    input  logic [15:0] A1,
    input  logic [15:0] A2,
    input  logic        in,
    output logic [15:0] S,
    output logic        C
);

    always_comb begin
        logic carry;
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        S     = '0;
        carry = in;
        for (int i = 0; i < 16; i++) begin
            S[i]  = A1[i] ^ A2[i] ^ carry;
            carry = (A1[i] & A2[i]) | (carry & (A1[i] ^ A2[i]));
        end
        C = carry;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Wide adder that reuses one RCA16 over NWORDS cycles, least-significant word first.
// Define MWADD_SUB_EN to add the 'sub' port (a - b via inverted B and forced carry-in).
module multiword_add_seq
    import mwadd_pkg::*;
#(
    parameter int NWORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] a,
    input  logic [WORD_W*NWORDS-1:0] b,
    input  logic                     cin,
`ifdef MWADD_SUB_EN
    input  logic                     sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int IDX_W = clog2(NWORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef logic [NWORDS-1:0][WORD_W-1:0] words_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    words_t           sum_q, sum_d;
    words_t           a_q, a_d;
    words_t           b_q, b_d;
`ifdef MWADD_SUB_EN
    logic             sub_q, sub_d;
`endif

    logic [WORD_W-1:0] add_a, add_b, add_s;
    logic              add_c;

    // Word-slice mux in front of the shared adder.
    always_comb begin
        add_a = a_q[idx_q];
        add_b = b_q[idx_q];
`ifdef MWADD_SUB_EN
        if (sub_q) begin
            add_b = ~b_q[idx_q];
        end
`endif
    end

    RCA16 u_rca16 (
        .A1 (add_a),
        .A2 (add_b),
        .in (carry_q),
        .S  (add_s),
        .C  (add_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef MWADD_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = cin;
`ifdef MWADD_SUB_EN
                    sub_d   = sub;
                    if (sub) begin
                        carry_d = 1'b1;
                    end
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q] = add_s;
                carry_d      = add_c;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_c;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
        end
    end

    // NOTE: operand registers are left unreset; they are always loaded before RUN reads them.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
`ifdef MWADD_SUB_EN
        sub_q <= sub_d;
`endif
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
